// File: rtl/encoder_scheduler_pkg.sv
// Shared FSM state type and default parameter values for the encoder scheduler
// and the stateEncoder it feeds.
package encoder_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    localparam int DEF_STATE_LENGTH   = 14;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ENABLE_CYCLES  = 3;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_REFRESH_PERIOD = 1000;

endpackage

// File: rtl/encoder_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;

    // rot_req[gi] is the request sitting gi places after the pointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                : sum[IDX_W-1:0];
            assign rot_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                valid  = 1'b1;
                winner = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/encoder_scheduler.sv
// Round-robin scheduler serialising one requester's state word at a time to stateEncoder.
// Define ENC_REFRESH_EN to retransmit the last word after REFRESH_PERIOD idle cycles.
module encoder_scheduler
    import encoder_scheduler_pkg::*;
#(
    parameter int STATE_LENGTH   = DEF_STATE_LENGTH,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ENABLE_CYCLES  = DEF_ENABLE_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
`ifdef ENC_REFRESH_EN
    ,
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
`endif
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*STATE_LENGTH-1:0] req_state,
    output logic [NUM_REQ-1:0]              grant,
    output logic [STATE_LENGTH-1:0]         enc_state,
    output logic                            enc_enable,
    output logic                            busy,
    output logic [2:0]                      last_src
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STATE_LENGTH + 16);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(STATE_LENGTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] EN_CNT    = CNT_W'(ENABLE_CYCLES);

    sched_state_t              state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [NUM_REQ-1:0]        grant_reg, grant_next;
    logic [STATE_LENGTH-1:0]   enc_state_reg, enc_state_next;
    logic                      enc_enable_reg, enc_enable_next;
    logic [IDX_W-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [2:0]                last_src_reg, last_src_next;
    logic [IDX_W-1:0]          win_idx;
    logic                      win_valid;
    logic                      refresh_due;
    logic [STATE_LENGTH-1:0]   slices [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign slices[gi] = req_state[gi*STATE_LENGTH +: STATE_LENGTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .winner (win_idx),
        .valid  (win_valid)
    );

`ifdef ENC_REFRESH_EN
    localparam int RW = $clog2(REFRESH_PERIOD + 1);
    logic [RW-1:0] idle_cnt_reg, idle_cnt_next;
    logic          primed_reg, primed_next;

    // primed blocks refreshes until something has actually been transmitted
    assign refresh_due = primed_reg && (idle_cnt_reg == RW'(REFRESH_PERIOD - 1));

    always_comb begin
        idle_cnt_next = '0;
        primed_next   = primed_reg || ((state_reg == IDLE) && win_valid);
        if ((state_reg == IDLE) && !win_valid && primed_reg && !refresh_due)
            idle_cnt_next = idle_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
            primed_reg   <= 1'b0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
            primed_reg   <= primed_next;
        end
    end
`else
    assign refresh_due = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        grant_next     = '0;
        enc_state_next = enc_state_reg;
        rr_ptr_next    = rr_ptr_reg;
        last_src_next  = last_src_reg;
        unique case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next          = LOAD;
                    grant_next[win_idx] = 1'b1;
                    enc_state_next      = slices[win_idx];
                    rr_ptr_next         = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    last_src_next       = 3'(win_idx);
                end else if (refresh_due) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SEND;
                cnt_next   = '0;
            end
            SEND: begin
                if (cnt_reg == SEND_LAST) begin
                    state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // registered so stateEncoder sees exactly one glitch-free rising edge
        enc_enable_next = (state_next == SEND) && (cnt_next < EN_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            grant_reg      <= '0;
            enc_state_reg  <= '0;
            enc_enable_reg <= 1'b0;
            rr_ptr_reg     <= '0;
            last_src_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            grant_reg      <= grant_next;
            enc_state_reg  <= enc_state_next;
            enc_enable_reg <= enc_enable_next;
            rr_ptr_reg     <= rr_ptr_next;
            last_src_reg   <= last_src_next;
        end
    end

    assign grant      = grant_reg;
    assign enc_state  = enc_state_reg;
    assign enc_enable = enc_enable_reg;
    assign busy       = (state_reg != IDLE);
    assign last_src   = last_src_reg;

endmodule

// File: tb/tb_encoder_scheduler.sv
// Self-checking bench for encoder_scheduler: directed table, hand sequences and a
// randomized phase, all judged by a transaction-timeline reference model.
module tb_encoder_scheduler;

    localparam int SL     = 14;
    localparam int NR     = 4;
    localparam int EN     = 3;
    localparam int GAPC   = 2;
    localparam int TX_LEN = 1 + SL + GAPC;   // cycles busy per transmission
`ifdef ENC_REFRESH_EN
    localparam int RP     = 50;
`endif

    localparam logic [SL-1:0] S0 = 14'h0660;
    localparam logic [SL-1:0] S1 = 14'h1ABC;
    localparam logic [SL-1:0] S2 = 14'h2345;
    localparam logic [SL-1:0] S3 = 14'h3F01;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*SL-1:0]  req_state;
    logic [NR-1:0]     grant;
    logic [SL-1:0]     enc_state;
    logic              enc_enable;
    logic              busy;
    logic [2:0]        last_src;

    int checks   = 0;
    int failures = 0;

    encoder_scheduler #(
        .STATE_LENGTH  (SL),
        .NUM_REQ       (NR),
        .ENABLE_CYCLES (EN),
        .GAP_CYCLES    (GAPC)
`ifdef ENC_REFRESH_EN
        ,
        .REFRESH_PERIOD(RP)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_state  (req_state),
        .grant      (grant),
        .enc_state  (enc_state),
        .enc_enable (enc_enable),
        .busy       (busy),
        .last_src   (last_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++)
            if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    // ---------------- reference model: one transmission = a start time ----------------
    longint        cyc     = 0;
    longint        m_load  = -1000;
    logic [NR-1:0] m_grant = '0;
    logic [SL-1:0] m_state = '0;
    logic [2:0]    m_last  = '0;
    int            m_ptr   = 0;
`ifdef ENC_REFRESH_EN
    bit            m_primed = 0;
    int            m_run    = 0;
`endif

    always @(negedge clk) begin
        logic [22:0] act_v, exp_v;
        logic        in_tx;
        int          w;
        if (!rst_n) begin
            m_load  = -1000;
            m_grant = '0;
            m_state = '0;
            m_last  = '0;
            m_ptr   = 0;
`ifdef ENC_REFRESH_EN
            m_primed = 0;
            m_run    = 0;
`endif
        end
        in_tx = (cyc >= m_load) && (cyc < m_load + TX_LEN);
        exp_v = {(cyc == m_load) ? m_grant : 4'b0000, m_state,
                 1'((cyc > m_load) && (cyc <= m_load + EN)), in_tx, m_last};
        act_v = {grant, enc_state, enc_enable, busy, last_src};
        chk($sformatf("cycle%0d_outputs{grant,state,en,busy,src}", cyc), 64'(act_v), 64'(exp_v));
        if (rst_n && !in_tx) begin
            if (req != '0) begin
                w       = pick(req, m_ptr);
                m_load  = cyc + 1;
                m_grant = NR'(1) << w;
                m_state = req_state[w*SL +: SL];
                m_last  = 3'(w);
                m_ptr   = (w + 1) % NR;
`ifdef ENC_REFRESH_EN
                m_primed = 1;
                m_run    = 0;
`endif
            end
`ifdef ENC_REFRESH_EN
            else if (m_primed) begin
                m_run++;
                if (m_run == RP) begin
                    m_run   = 0;
                    m_load  = cyc + 1;
                    m_grant = '0;
                end
            end
`endif
        end
`ifdef ENC_REFRESH_EN
        else begin
            m_run = 0;
        end
`endif
        cyc++;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        failures++;
        $display("FAIL idle_timeout busy=%0b required=0", busy);
    endtask

    task automatic wait_grant(output logic [NR-1:0] g, output longint t);
        g = '0;
        t = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (grant != '0) begin
                g = grant;
                t = $time;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL grant_timeout grant=0x%0h required=nonzero", grant);
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_grant;
        logic [SL-1:0] exp_state;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] g;
        logic [NR-1:0] pend;
        logic [SL-1:0] held;
        longint        t0, t1, tp;
        int            n, gcount, exp_rises;
        logic          prev;
        longint        rise_t [$];

        // Requester order assumes the pointer sequence starting from reset.
        vecs[0] = '{4'b0001, 4'b0001, S0};
        vecs[1] = '{4'b1111, 4'b0010, S1};
        vecs[2] = '{4'b0001, 4'b0001, S0};
        vecs[3] = '{4'b0101, 4'b0100, S2};
        vecs[4] = '{4'b0101, 4'b0001, S0};
        vecs[5] = '{4'b1000, 4'b1000, S3};
        vecs[6] = '{4'b0110, 4'b0010, S1};
        vecs[7] = '{4'b1001, 4'b1000, S3};

        rst_n     = 1'b0;
        req       = '0;
        req_state = {S3, S2, S1, S0};
        repeat (3) tick();
        rst_n = 1'b1;

        // Directed table: winner, captured word, enable latency, busy length
        for (int v = 0; v < 8; v++) begin
            wait_idle();
            tick();
            req = vecs[v].req;
            wait_grant(g, t0);
            chk($sformatf("tbl%0d_grant", v), 64'(g), 64'(vecs[v].exp_grant));
            chk($sformatf("tbl%0d_enc_state", v), 64'(enc_state), 64'(vecs[v].exp_state));
            tick();
            req = '0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) chk($sformatf("tbl%0d_enable_latency", v), 64'(enc_enable), 64'(1));
            end while (busy && n < 40);
            chk($sformatf("tbl%0d_busy_len", v), 64'(n), 64'(TX_LEN));
        end

        // All four requesting, each released on its grant
        wait_idle();
        tick();
        req = 4'b1111;
        tp  = 0;
        for (int k = 0; k < NR; k++) begin
            wait_grant(g, t1);
            chk($sformatf("all_order%0d", k), 64'(g), 64'(NR'(1) << k));
            if (k > 0) chk($sformatf("all_spacing%0d", k), 64'((t1 - tp) / 10), 64'(TX_LEN + 1));
            tp = t1;
            tick();
            req = req & ~g;
        end

        // Fairness with two requesters held continuously
        wait_idle();
        tick();
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, t1);
            chk($sformatf("fair%0d", k), 64'(g), 64'((k % 2 == 0) ? 4'b0001 : 4'b0100));
            tick();
        end
        req = '0;

        // Request and word change during SEND wait for the next IDLE
        wait_idle();
        tick();
        req = 4'b0001;
        wait_grant(g, t0);
        chk("mid_first_grant", 64'(g), 64'(4'b0001));
        tick();
        req = '0;
        repeat (3) tick();
        req_state[1*SL +: SL] = 14'h2AAA;
        req = 4'b0010;
        wait_grant(g, t1);
        chk("mid_second_grant", 64'(g), 64'(4'b0010));
        chk("mid_grant_delay", 64'((t1 - t0) / 10), 64'(TX_LEN + 1));
        chk("mid_enc_state", 64'(enc_state), 64'(14'h2AAA));
        tick();
        req = '0;

        // Asynchronous reset in the middle of SEND
        wait_idle();
        tick();
        req = 4'b0100;
        wait_grant(g, t0);
        chk("rst_pre_grant", 64'(g), 64'(4'b0100));
        tick();
        req = '0;
        tick();
        #2;
        chk("rst_pre_enable", 64'(enc_enable), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop{en,busy}", 64'({enc_enable, busy}), 64'(2'b00));
        repeat (3) tick();
        rst_n = 1'b1;
        req   = 4'b1010;
        wait_grant(g, t1);
        chk("rst_post_grant", 64'(g), 64'(4'b0010));
        tick();
        req = '0;

        // Randomized traffic, including requests withdrawn before their grant
        for (int k = 0; k < 800; k++) begin
            tick();
            pend = req & ~grant;
            if ($urandom_range(0, 7) == 0) pend = pend | NR'($urandom);
            if ($urandom_range(0, 15) == 0) pend = pend & ~(NR'(1) << $urandom_range(0, NR - 1));
            req = pend;
            if ($urandom_range(0, 3) == 0)
                req_state[$urandom_range(0, NR - 1)*SL +: SL] = SL'($urandom);
        end
        tick();
        req = '0;

        // Long idle window after one grant: refresh behaviour (or its absence)
        wait_idle();
        tick();
        req = 4'b0001;
        wait_grant(g, t0);
        tick();
        req = '0;
        wait_idle();
        held   = enc_state;
        prev   = enc_enable;
        gcount = 0;
        for (int k = 0; k < 210; k++) begin
            if (k > 0) @(negedge clk);
            if (enc_enable && !prev) rise_t.push_back(k);
            prev = enc_enable;
            if (grant != '0) gcount++;
        end
`ifdef ENC_REFRESH_EN
        exp_rises = 3;
`else
        exp_rises = 0;
`endif
        chk("idle_enable_rises", 64'(rise_t.size()), 64'(exp_rises));
        chk("idle_grant_count", 64'(gcount), 64'(0));
        chk("idle_enc_state", 64'(enc_state), 64'(held));
`ifdef ENC_REFRESH_EN
        if (rise_t.size() == 3) begin
            chk("refresh_first_rise", 64'(rise_t[0]), 64'(RP + 1));
            chk("refresh_period1", 64'(rise_t[1] - rise_t[0]), 64'(RP + TX_LEN));
            chk("refresh_period2", 64'(rise_t[2] - rise_t[1]), 64'(RP + TX_LEN));
        end
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
